// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral
//
// Memory-mapped 8N1 UART transmitter. It sits on the core's data bus behind
// the top-level address decode. Stores to DATA queue one byte in a small
// circular FIFO. An FSM serialises each byte onto tx, LSB first, with one
// start bit and one stop bit.
//
// Register map (word-decoded on memory_address[31:2]):
//   DATA   @ BASE_ADDRESS     write [7:0] pushes a byte; reads return 0
//   STATUS @ BASE_ADDRESS + 4 [0] full, [1] empty, [2] busy (FSM not idle),
//                             [3] overflow (sticky, write 1 to clear),
//                             [7:4] fifo count
//
// Bus protocol: there is no stall or handshake. A store is one cycle with
// memory_write_sections != 0, and it is always consumed. If a DATA store
// arrives while the FIFO is full and nothing drains that cycle, the byte is
// dropped and overflow is set. Reads have a fixed one-cycle latency.
// read_valid is high on the edge after any DATA or STATUS address,
// independent of the sections, so the top-level read mux can select on it.
//
// Ports:
//   clk24                  core clock (24 MHz)
//   reset                  asynchronous, active-high
//   memory_address         byte address; bits [1:0] ignored
//   memory_write_value     lane-shifted store data
//   memory_write_sections  byte-lane write enables
//   read_value             registered read data
//   read_valid             read_value belongs to this block
//   tx                     serial output, idle high, registered
//   tx_busy                FIFO non-empty or FSM not idle, registered

module uart_tx_peripheral #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h80000018,
    parameter int          CLOCKS_PER_BIT = 208,
    parameter int          FIFO_DEPTH     = 4
) (
    input  logic        clk24,
    input  logic        reset,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_value,
    input  logic [3:0]  memory_write_sections,
    output logic [31:0] read_value,
    output logic        read_valid,
    output logic        tx,
    output logic        tx_busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BCNT_W = $clog2(CLOCKS_PER_BIT);

    localparam logic [29:0]       DATA_WORD   = BASE_ADDRESS[31:2];
    localparam logic [29:0]       STATUS_WORD = BASE_ADDRESS[31:2] + 30'd1;
    localparam logic [BCNT_W-1:0] BIT_LAST    = BCNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;

    logic [7:0]          fifo_mem_q [FIFO_DEPTH];
    logic [7:0]          fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;

    logic                read_valid_q, read_valid_d;
    logic [31:0]         read_value_q, read_value_d;

    logic [29:0]         addr_word;
    logic                hit_data, hit_status;
    logic                fifo_full, fifo_empty;
    logic                pop, push_req, push;
    logic [31:0]         status_word;

    // Bits of the bus this block never looks at.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{memory_address[1:0], memory_write_value[31:8],
                               memory_write_sections[3:1]};

    assign addr_word  = memory_address[31:2];
    assign hit_data   = (addr_word == DATA_WORD);
    assign hit_status = (addr_word == STATUS_WORD);
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign fifo_empty = (count_q == '0);

    // Serialiser FSM. A pop loads the shift register and drives the start
    // bit on the same edge. In DATA, tx always carries shift_q[0], so the
    // next bit is shift_q[1] just before the shift.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_mem_q[rd_ptr_q];
                    tx_d      = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (!fifo_empty) begin
                        // Back-to-back frame: no idle gap after the stop bit.
                        pop     = 1'b1;
                        shift_d = fifo_mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO and overflow. A pop on the same edge frees the slot that a push
    // into a full FIFO needs, so that push is accepted.
    always_comb begin
        push_req   = hit_data && memory_write_sections[0];
        push       = push_req && (!fifo_full || pop);
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            fifo_mem_d[wr_ptr_q] = memory_write_value[7:0];
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (hit_status && memory_write_sections[0] && memory_write_value[3]) begin
            overflow_d = 1'b0;
        end
        if (push_req && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end

        busy_d = (count_d != '0) || (state_d != ST_IDLE);
    end

    // The read path samples the current register state, so a STATUS read
    // does not see this edge's updates.
    always_comb begin
        status_word  = {24'd0, 4'(count_q), overflow_q, (state_q != ST_IDLE),
                        fifo_empty, fifo_full};
        read_valid_d = hit_data || hit_status;
        read_value_d = hit_status ? status_word : 32'd0;
    end

    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 8'd0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            read_valid_q <= 1'b0;
            read_value_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            read_valid_q <= read_valid_d;
            read_value_q <= read_value_d;
        end
    end

    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign read_valid = read_valid_q;
    assign read_value = read_value_q;

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Testbench for uart_tx_peripheral.
// The stimulus process queues the expected read responses and frame bytes.
// The read monitor and the serial receiver pop those entries and compare
// them against what the DUT presents.

module tb_uart_tx_peripheral;

    localparam int          CPB         = 208;
    localparam logic [31:0] DATA_ADDR   = 32'h80000018;
    localparam logic [31:0] STATUS_ADDR = 32'h8000001C;
    localparam logic [31:0] OTHER_ADDR  = 32'h80000010;
    localparam logic [31:0] ALL_BITS    = 32'hFFFF_FFFF;

    logic        clk24 = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] memory_address = 32'd0;
    logic [31:0] memory_write_value = 32'd0;
    logic [3:0]  memory_write_sections = 4'd0;
    logic [31:0] read_value;
    logic        read_valid;
    logic        tx;
    logic        tx_busy;

    uart_tx_peripheral #(
        .BASE_ADDRESS  (DATA_ADDR),
        .CLOCKS_PER_BIT(CPB),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk24                (clk24),
        .reset                (reset),
        .memory_address       (memory_address),
        .memory_write_value   (memory_write_value),
        .memory_write_sections(memory_write_sections),
        .read_value           (read_value),
        .read_valid           (read_valid),
        .tx                   (tx),
        .tx_busy              (tx_busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk24 = ~clk24;

    int cyc = 0;
    always @(posedge clk24) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          tests_run = 0;
    int          tests_failed = 0;
    int          last_drive = 0;
    int          exp_rd_cyc[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_rd_mask[$];
    logic [7:0]  exp_q[$];
    int          frame_start_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] status_word(input int count, input bit ovf,
                                                input bit busy, input bit empty, input bit full);
        return {24'd0, 4'(count), ovf, busy, empty, full};
    endfunction

    // ---------------- driver tasks ----------------
    // Each call occupies one bus cycle: inputs change on the falling edge and
    // are taken by the following rising edge.
    task automatic bus_op(input logic [31:0] addr, input logic [31:0] val, input logic [3:0] sec,
                          input logic [31:0] exp, input logic [31:0] mask);
        @(negedge clk24);
        memory_address        = addr;
        memory_write_value    = val;
        memory_write_sections = sec;
        last_drive            = cyc;
        if (addr == DATA_ADDR || addr == STATUS_ADDR) begin
            exp_rd_cyc.push_back(cyc + 1);
            exp_rd_q.push_back(exp);
            exp_rd_mask.push_back(mask);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] val, input logic [3:0] sec);
        // A store still produces read_valid. DATA reads back 0; the STATUS
        // value seen under a store is not checked.
        bus_op(addr, val, sec, 32'd0, (addr == DATA_ADDR) ? ALL_BITS : 32'd0);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
        bus_op(addr, 32'd0, 4'd0, exp, ALL_BITS);
    endtask

    task automatic bus_idle();
        @(negedge clk24);
        memory_address        = 32'd0;
        memory_write_value    = 32'd0;
        memory_write_sections = 4'd0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk24);
    endtask

    // ---------------- read monitor ----------------
    logic [31:0] mon_exp, mon_mask;
    always @(negedge clk24) begin
        if (!reset) begin
            if (exp_rd_cyc.size() > 0 && exp_rd_cyc[0] == cyc) begin
                void'(exp_rd_cyc.pop_front());
                mon_exp  = exp_rd_q.pop_front();
                mon_mask = exp_rd_mask.pop_front();
                check("read_valid", 32'(read_valid), 32'd1);
                if (mon_mask != 32'd0)
                    check("read_value", read_value & mon_mask, mon_exp & mon_mask);
            end else if (read_valid) begin
                check("read_valid_spurious", 32'(read_valid), 32'd0);
            end
        end
    end

    // ---------------- serial receiver ----------------
    // Every one of the CPB samples of a bit must match the first sample of
    // that bit. This checks the exact bit width as well as the bit value.
    bit         rx_active = 1'b0;
    bit         rx_glitch = 1'b0;
    int         rx_cnt = 0;
    logic [9:0] rx_bits = '0;
    always @(negedge clk24) begin
        if (reset) begin
            rx_active = 1'b0;
        end else begin
            if (!rx_active && tx == 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                rx_glitch = 1'b0;
                rx_bits   = '0;
                frame_start_q.push_back(cyc);
            end
            if (rx_active) begin
                if (rx_cnt % CPB == 0) rx_bits[rx_cnt / CPB] = tx;
                else if (tx !== rx_bits[rx_cnt / CPB]) rx_glitch = 1'b1;
                rx_cnt++;
                if (rx_cnt == 10 * CPB) begin
                    rx_active = 1'b0;
                    check("frame_format", 32'({rx_glitch, rx_bits[9], rx_bits[0]}), 32'b010);
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL frame_unexpected: got byte %h expected no frame (cycle %0d)",
                                 rx_bits[8:1], cyc);
                    end else begin
                        check("frame_byte", 32'(rx_bits[8:1]), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic wait_drain(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk24);
            if (!tx_busy && !rx_active && exp_q.size() == 0) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int c, a, f;
    initial begin
        // Reset state while reset is held.
        repeat (3) @(negedge clk24);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_read_valid", 32'(read_valid), 32'd0);
        check("rst_read_value", read_value, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk24);

        // --- Single frame 0x55 ---
        frame_start_q.delete();
        exp_q.push_back(8'h55);
        bus_write(DATA_ADDR, 32'h55, 4'b0001);
        c = last_drive;
        bus_idle();
        wait_cyc(c + 1);
        check("t1_busy_after_push", 32'(tx_busy), 32'd1);
        check("t1_tx_before_start", 32'(tx), 32'd1);
        wait_cyc(c + 2);
        check("t1_tx_start", 32'(tx), 32'd0);
        wait_cyc(c + 2081);
        check("t1_busy_in_stop", 32'(tx_busy), 32'd1);
        check("t1_tx_stop", 32'(tx), 32'd1);
        wait_cyc(c + 2082);
        check("t1_busy_after", 32'(tx_busy), 32'd0);
        check("t1_start_cycle", frame_start_q.pop_front(), c + 2);

        // --- Three back-to-back frames ---
        repeat (5) @(negedge clk24);
        frame_start_q.delete();
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        bus_write(DATA_ADDR, 32'h41, 4'b0001);
        c = last_drive;
        bus_write(DATA_ADDR, 32'h42, 4'b0001);
        bus_write(DATA_ADDR, 32'h43, 4'b0001);
        bus_idle();
        wait_cyc(c + 100);
        bus_read(STATUS_ADDR, status_word(2, 0, 1, 0, 0));
        bus_idle();
        wait_cyc(c + 6241);
        check("t2_busy_end", 32'(tx_busy), 32'd1);
        wait_cyc(c + 6242);
        check("t2_idle_end", 32'(tx_busy), 32'd0);
        check("t2_start0", frame_start_q.pop_front(), c + 2);
        check("t2_start1", frame_start_q.pop_front(), c + 2 + 10 * CPB);
        check("t2_start2", frame_start_q.pop_front(), c + 2 + 20 * CPB);

        // --- Overflow with FSM busy, clear, and push on STOP pop when full ---
        repeat (5) @(negedge clk24);
        exp_q.push_back(8'hA0);
        bus_write(DATA_ADDR, 32'hA0, 4'b0001);
        a = last_drive;
        bus_idle();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(8'hB0 + 8'(i));
            bus_write(DATA_ADDR, 32'hB0 + i, 4'b0001);
        end
        bus_read(STATUS_ADDR, status_word(4, 1, 1, 0, 1));
        bus_write(STATUS_ADDR, 32'h08, 4'b0001);
        bus_read(STATUS_ADDR, status_word(4, 0, 1, 0, 1));
        bus_idle();
        wait_cyc(a + 2080);
        exp_q.push_back(8'hC0);
        bus_write(DATA_ADDR, 32'hC0, 4'b0001);
        check("t4_push_on_pop_cycle", last_drive, a + 2081);
        bus_read(STATUS_ADDR, status_word(4, 0, 1, 0, 1));
        bus_idle();
        wait_drain(16000, "t3_drain");

        // --- Reset during data bit 3 ---
        repeat (5) @(negedge clk24);
        frame_start_q.delete();
        exp_q.push_back(8'h5A);
        bus_write(DATA_ADDR, 32'h5A, 4'b0001);
        c = last_drive;
        bus_idle();
        f = c + 2;
        wait_cyc(f + 4 * CPB + 100);
        check("t5_tx_bit3", 32'(tx), 32'd1);   // 0x5A bit 3 is 1
        #3 reset = 1'b1;
        #1;
        check("t5_rst_tx", 32'(tx), 32'd1);
        check("t5_rst_busy", 32'(tx_busy), 32'd0);
        exp_q.delete();
        exp_rd_cyc.delete();
        exp_rd_q.delete();
        exp_rd_mask.delete();
        repeat (2) @(negedge clk24);
        reset = 1'b0;
        frame_start_q.delete();
        bus_read(STATUS_ADDR, status_word(0, 0, 0, 1, 0));
        bus_idle();
        repeat (2500) @(negedge clk24);
        check("t5_no_frame", frame_start_q.size(), 0);
        check("t5_idle_busy", 32'(tx_busy), 32'd0);

        // --- Read decode and ignored lane writes ---
        bus_read(DATA_ADDR, 32'd0);
        bus_read(STATUS_ADDR, status_word(0, 0, 0, 1, 0));
        bus_read(OTHER_ADDR, 32'd0);
        c = last_drive;
        bus_idle();
        check("t6_other_valid", 32'(read_valid), 32'd0);
        bus_write(DATA_ADDR, 32'h0000_7777, 4'b0010);
        bus_idle();
        repeat (300) @(negedge clk24);
        check("t6_no_frame", frame_start_q.size(), 0);
        check("t6_busy", 32'(tx_busy), 32'd0);
        bus_read(STATUS_ADDR, status_word(0, 0, 0, 1, 0));
        bus_idle();
        repeat (4) @(negedge clk24);

        check("end_reads_drained", exp_rd_cyc.size(), 0);
        check("end_bytes_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
